// File: rtl/aes_tx_if.sv
// aes_tx_if: block load handshake and byte-serial strobe bus of the AES port transmitter
interface aes_tx_if;
  logic [127:0] data_in;
  logic         load;
  logic         ready;
  logic [7:0]   tx;
  logic         shakehand;
  logic         busy;
  logic         done;
  modport master (output data_in, load, input ready, tx, shakehand, busy, done);
  modport slave  (input data_in, load, output ready, tx, shakehand, busy, done);
endinterface

// File: rtl/aes_tx.sv
// aes_tx: 128-bit block to 16 MSB-first bytes with a 0->1 shakehand strobe per byte; AES_TX_DBUF_EN adds a one-entry pending block buffer
module aes_tx #(
  parameter int SETUP_CYC = 1,
  parameter int HIGH_CYC  = 1
) (
  input logic   clk,
  input logic   rst,
  aes_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;
  state_t         state;
  logic [3:0]     k;
  logic [7:0]     ph;
  logic [127:0]   shift;
  logic           acc;
  logic           last;
  logic           chain;
  logic [127:0]   chain_blk;
  assign acc  = bus.load & bus.ready;
  assign last = (state == STROBE) && (ph == 8'(HIGH_CYC - 1)) && (k == 4'd15);
`ifdef AES_TX_DBUF_EN
  logic         pend_v;
  logic [127:0] pend;
  assign bus.ready = ~pend_v;
  assign chain     = pend_v | acc;
  assign chain_blk = pend_v ? pend : bus.data_in;
  // park a block that arrives while one is in flight; the last strobe exit consumes it
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend   <= '0;
    end else if (last && pend_v) begin
      pend_v <= 1'b0;
    end else if (acc && state != IDLE && !last) begin
      pend_v <= 1'b1;
      pend   <= bus.data_in;
    end
  end
`else
  assign bus.ready = (state == IDLE);
  assign chain     = 1'b0;
  assign chain_blk = bus.data_in;
`endif
  // byte sequencer: SETUP holds tx with strobe low, STROBE raises it; tx only moves on SETUP entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      ph            <= '0;
      shift         <= '0;
      bus.tx        <= '0;
      bus.shakehand <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            state    <= SETUP;
            k        <= '0;
            ph       <= '0;
            shift    <= bus.data_in;
            bus.tx   <= bus.data_in[127:120];
            bus.busy <= 1'b1;
          end
        end
        SETUP: begin
          if (ph == 8'(SETUP_CYC - 1)) begin
            state         <= STROBE;
            ph            <= '0;
            bus.shakehand <= 1'b1;
          end else begin
            ph <= ph + 8'd1;
          end
        end
        STROBE: begin
          if (ph == 8'(HIGH_CYC - 1)) begin
            bus.shakehand <= 1'b0;
            ph            <= '0;
            if (k != 4'd15) begin
              state  <= SETUP;
              k      <= k + 4'd1;
              shift  <= shift << 8;
              bus.tx <= shift[119:112];
            end else begin
              bus.done <= 1'b1;
              k        <= '0;
              if (chain) begin
                state    <= SETUP;
                shift    <= chain_blk;
                bus.tx   <= chain_blk[127:120];
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end
          end else begin
            ph <= ph + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_tx.sv
// tb_aes_tx: randomized check of two aes_tx instances (1/1 and 3/2 timing) against a timing-formula model
module tb_aes_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes_tx_if b0 ();
  aes_tx_if b1 ();
  aes_tx u0 (.clk(clk), .rst(rst), .bus(b0));
  aes_tx #(.SETUP_CYC(3), .HIGH_CYC(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {
    int           lane;
    int           a;
    int           s;
    logic [127:0] d;
  } blk_t;
  localparam logic [127:0] B0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] B1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  blk_t         q[$];
  int           sc[2] = '{1, 3};
  int           hc[2] = '{1, 2};
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   last_tx[2] = '{8'h00, 8'h00};
  logic         prev_sh[2] = '{1'b0, 1'b0};
  logic [127:0] cap_v[2] = '{128'h0, 128'h0};
  int           cap_n[2] = '{0, 0};
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [7:0] byte_of(input logic [127:0] d, input int k);
    logic [127:0] t;
    t = d >> (8 * (15 - k));
    return t[7:0];
  endfunction
  // expected port state of a lane in cycle n, from block start cycles and the byte-period formulas
  task automatic expect_at(input int l, input int n, output logic [7:0] tx, output logic sh,
                           output logic busy, output logic done, output logic ready,
                           output logic [127:0] dd);
    int p;
    p = sc[l] + hc[l];
    tx = last_tx[l]; sh = 1'b0; busy = 1'b0; done = 1'b0; ready = 1'b1; dd = '0;
    foreach (q[i]) begin
      if (q[i].lane == l) begin
        if (n > q[i].s && n <= q[i].s + 16 * p) begin
          busy = 1'b1;
          tx   = byte_of(q[i].d, (n - q[i].s - 1) / p);
          sh   = ((n - q[i].s - 1) % p) >= sc[l];
        end
        if (n == q[i].s + 16 * p + 1) begin
          done = 1'b1;
          dd   = q[i].d;
        end
`ifdef AES_TX_DBUF_EN
        if (q[i].a < n && n <= q[i].s && q[i].a != q[i].s) ready = 1'b0;
`endif
      end
    end
`ifndef AES_TX_DBUF_EN
    ready = !busy;
`endif
  endtask
  task automatic step(input logic [1:0] ld, input logic [127:0] d0, input logic [127:0] d1, input logic r);
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      logic [7:0] otx, etx;
      logic osh, obusy, odone, ordy, esh, ebusy, edone, erdy;
      logic [127:0] edd;
      blk_t nb;
      int ls;
      otx   = l ? b1.tx : b0.tx;
      osh   = l ? b1.shakehand : b0.shakehand;
      obusy = l ? b1.busy : b0.busy;
      odone = l ? b1.done : b0.done;
      ordy  = l ? b1.ready : b0.ready;
      expect_at(l, cyc, etx, esh, ebusy, edone, erdy, edd);
      chk($sformatf("tx%0d", l), 128'(otx), 128'(etx));
      chk($sformatf("shakehand%0d", l), 128'(osh), 128'(esh));
      chk($sformatf("busy%0d", l), 128'(obusy), 128'(ebusy));
      chk($sformatf("done%0d", l), 128'(odone), 128'(edone));
      chk($sformatf("ready%0d", l), 128'(ordy), 128'(erdy));
      last_tx[l] = etx;
      if (osh && !prev_sh[l]) begin
        cap_v[l] = {cap_v[l][119:0], otx};
        cap_n[l]++;
      end
      prev_sh[l] = osh;
      if (edone) begin
        chk($sformatf("strobes%0d", l), 128'(cap_n[l]), 128'd16);
        chk($sformatf("rx_block%0d", l), cap_v[l], edd);
        cap_n[l] = 0;
      end
      if (!r && ld[l] && erdy) begin
        ls = -100000;
        foreach (q[i]) if (q[i].lane == l && q[i].s > ls) ls = q[i].s;
        nb.lane = l;
        nb.a    = cyc;
        nb.s    = ebusy ? ls + 16 * (sc[l] + hc[l]) : cyc;
        nb.d    = l ? d1 : d0;
        q.push_back(nb);
      end
    end
    if (r) begin
      q.delete();
      last_tx = '{8'h00, 8'h00};
      prev_sh = '{1'b0, 1'b0};
      cap_n   = '{0, 0};
    end
    rst        = r;
    b0.load    = ld[0];
    b0.data_in = d0;
    b1.load    = ld[1];
    b1.data_in = d1;
    @(posedge clk);
    cyc++;
  endtask
  initial begin
    b0.load = 1'b0; b0.data_in = '0;
    b1.load = 1'b0; b1.data_in = '0;
    repeat (3) @(posedge clk);
    step(2'b00, '0, '0, 1'b1);
    step(2'b00, '0, '0, 1'b0);
    step(2'b11, B0, B1, 1'b0);
    repeat (9) step(2'b00, '0, '0, 1'b0);
    step(2'b11, ~B0, ~B1, 1'b0);
    repeat (180) step(2'b00, '0, '0, 1'b0);
    step(2'b11, B1, B0, 1'b0);
    repeat (15) step(2'b00, '0, '0, 1'b0);
    step(2'b00, '0, '0, 1'b1);
    step(2'b00, '0, '0, 1'b0);
    step(2'b11, B0, B1, 1'b0);
    repeat (100) step(2'b00, '0, '0, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      logic [1:0] ld;
      ld = {($urandom % 16) == 0, ($urandom % 16) == 0};
      step(ld, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 500) == 0);
    end
    repeat (200) step(2'b00, '0, '0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
